// File: rtl/dmem_sized_ctrl.sv
// Sized little-endian data memory, valid/ready request, fixed-latency response.
// Define DMEM_ALIGN_CHK_EN to reject addresses not aligned to the access size.
module dmem_sized_ctrl #(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 64,
  parameter int MEM_BYTES_LOG2 = 16,
  parameter int LAT            = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int NBMAX = DATA_W / 8;
  localparam int DEPTH = 1 << MEM_BYTES_LOG2;
  localparam logic [ADDR_W:0] MEM_END =
    {{ADDR_W{1'b0}}, 1'b1} << MEM_BYTES_LOG2;
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ready_q;
  logic                rvalid_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [7:0] mem [DEPTH];

  logic [3:0]                nb;
  logic [ADDR_W:0]           end_addr;
  logic                      size_err;
  logic                      range_err;
  logic                      align_err;
  logic                      err_d;
  logic [MEM_BYTES_LOG2-1:0] idx;
  logic                      fire;
  logic [DATA_W-1:0]         rdata_d;

  always_comb begin
    nb       = 4'd1 << size_q;
    size_err = (int'(nb) * 8) > DATA_W;
    // Sum is one bit wider than the address so a top-of-space address can't wrap.
    end_addr = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, nb};
    range_err = end_addr > MEM_END;
`ifdef DMEM_ALIGN_CHK_EN
    align_err = |(addr_q[3:0] & (nb - 4'd1));
`else
    align_err = 1'b0;
`endif
    err_d = size_err | range_err | align_err;
    idx   = addr_q[MEM_BYTES_LOG2-1:0];
    fire  = (state_q == S_WAIT) && (cnt_q == 3'd0);
  end

  always_comb begin
    rdata_d = '0;
    if (!err_d && !we_q) begin
      for (int k = 0; k < NBMAX; k++) begin
        if (k < int'(nb)) begin
          rdata_d[8*k +: 8] = mem[idx + MEM_BYTES_LOG2'(k)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fire && we_q && !err_d) begin
      for (int k = 0; k < NBMAX; k++) begin
        if (k < int'(nb)) begin
          mem[idx + MEM_BYTES_LOG2'(k)] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && ready_q) begin
            we_q    <= req_we;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= CNT_INIT;
            ready_q <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            ready_q  <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: doc/dmem_sized_ctrl.md
Name: dmem_sized_ctrl

Overview:
Parametrised byte-addressed, little-endian data memory with a valid/ready request port and a fixed-latency response port, for the memory stage of the Y86-64 pipeline. It supports 1/2/4/8-byte sized accesses and reports out-of-range accesses as an error response. The memory array is never modified by reset.

Parameters:
DATA_W, 64, word width in bits; multiple of 8, at most 64.
ADDR_W, 64, request address width in bits.
MEM_BYTES_LOG2, 16, array holds 2**MEM_BYTES_LOG2 bytes.
LAT, 1, cycles from request acceptance to resp_valid; legal values 1..8.

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = write, 0 = read
req_size  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B
req_addr  in  ADDR_W  byte address of the lowest byte
req_wdata  in  DATA_W  write data; low (1<<req_size) bytes are used
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  DATA_W  read data, zero-extended
resp_err  out  1  access rejected (dmem_err)

Behaviour:
- State machine: IDLE -> WAIT -> IDLE.
- IDLE: req_ready=1. A request is accepted on the edge where req_valid&req_ready=1. On acceptance, latch we, size, addr and wdata, load the latency counter with LAT-1, and go to WAIT.
- WAIT: req_ready=0. The counter decrements each cycle. When the counter is 0, perform the access, drive the response outputs and return to IDLE.
- Response timing: resp_valid is registered, high for exactly 1 cycle, LAT cycles after the acceptance edge. Back-to-back throughput is one request per LAT+1 cycles.
- Byte count: nb = 1<<size. If nb*8 > DATA_W, the request is an error.
- Range error: addr + nb > 2**MEM_BYTES_LOG2, computed at ADDR_W+1 bits so there is no wrap, is an error.
- On error: no array write, resp_rdata=0, resp_err=1.
- Read: resp_rdata[8k+7:8k] = mem[addr+k] for k < nb. Upper bytes are 0.
- Write: mem[addr+k] = wdata[8k+7:8k] for k < nb. resp_rdata=0, resp_err=0, resp_valid still pulses.
- Array updates and read sampling occur on the same response edge. A read issued after a write's response sees the written data.
- Reset, including mid-WAIT: state=IDLE, counter=0, req_ready=1 on the cycle after reset, resp_valid=0, resp_rdata=0, resp_err=0.
  - Any in-flight request is dropped: no write, no response.
  - Array contents are unchanged.
  - Requests are ignored while reset=1.
- Outputs other than resp_valid hold their last value until the next response.

Optional Feature:
Macro DMEM_ALIGN_CHK_EN.
- Defined: an address that is not a multiple of nb (addr & (nb-1) != 0) is an error, handled identically to a range error.
- Undefined: misaligned accesses are legal and byte-granular; only size and range errors apply.

Test Plan:
- LAT=1: write size 3 at addr 0x10 with 0x1122334455667788, then read size 3 at 0x10 -> resp_rdata=0x1122334455667788, err=0. resp_valid rises 1 cycle after each acceptance.
- After the above, read size 0 at 0x12 -> 0x66; read size 1 at 0x16 -> 0x1122; read size 2 at 0x14 -> 0x11223344.
- Read size 3 at 0xFFFC (MEM_BYTES_LOG2=16) -> err=1, rdata=0. A write there does not alter bytes 0xFFFC..0xFFFF (verified by size-0 reads).
- LAT=4: req_valid held high -> accept, req_ready=0 for 4 cycles, resp_valid on cycle 4, next accept on cycle 5. Assert reset during WAIT -> no resp_valid, memory unchanged, req_ready=1 after reset.
- Size-2 write at 0x21 (misaligned): without DMEM_ALIGN_CHK_EN -> err=0 and the data reads back. With DMEM_ALIGN_CHK_EN -> err=1 and the bytes are unchanged.
